// File: rtl/bm_pkg.sv
// Shared encodings for the bit-manipulation unit: the decoded operation and the
// direction input values.
package bm_pkg;

   typedef enum logic [2:0] {
      BM_PASS,
      BM_SHL,
      BM_SHR,
      BM_ROL,
      BM_ROR
   } bm_op_e;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage : bm_pkg

// File: rtl/bm_core.sv
// Combinational core: decodes the enables and directions into one operation,
// then forms the next result and the bit that leaves the operand.
module bm_core
   import bm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             enable_shift_i,
   input  logic             direction_shift_i,
   input  logic             enable_rotate_i,
   input  logic             direction_rotate_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o
);

   bm_op_e op;

   // Shift outranks rotate, so each direction bit only matters under its own enable.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path can infer a latch.
      op = BM_PASS;
      if (enable_shift_i) begin
         op = (direction_shift_i == DIR_RIGHT) ? BM_SHR : BM_SHL;
      end else if (enable_rotate_i) begin
         op = (direction_rotate_i == DIR_RIGHT) ? BM_ROR : BM_ROL;
      end
   end

   always_comb begin
      result_o = data_i;
      carry_o  = 1'b0;
      case (op)
         BM_SHL: begin
            result_o = {data_i[WIDTH-2:0], 1'b0};
            carry_o  = data_i[WIDTH-1];
         end
         BM_SHR: begin
            result_o = {1'b0, data_i[WIDTH-1:1]};
            carry_o  = data_i[0];
         end
         BM_ROL: begin
            result_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
            carry_o  = data_i[WIDTH-1];
         end
         BM_ROR: begin
            result_o = {data_i[0], data_i[WIDTH-1:1]};
            carry_o  = data_i[0];
         end
         default: begin
            result_o = data_i;
            carry_o  = 1'b0;
         end
      endcase
   end

endmodule : bm_core

// File: rtl/bit_manipulation.sv
// Registered single-position shift/rotate unit: one operation per cycle,
// result and carry appear one clock after the operands are sampled.
module bit_manipulation
   import bm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             enable_shift,
   input  logic             direction_shift,
   input  logic             enable_rotate,
   input  logic             direction_rotate,
   output logic [WIDTH-1:0] data_out,
   output logic             carry
);

   logic [WIDTH-1:0] data_out_d, data_out_q;
   logic             carry_d, carry_q;

   bm_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .data_i            (data_in),
      .enable_shift_i    (enable_shift),
      .direction_shift_i (direction_shift),
      .enable_rotate_i   (enable_rotate),
      .direction_rotate_i(direction_rotate),
      .result_o          (data_out_d),
      .carry_o           (carry_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         data_out_q <= '0;
         carry_q    <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         carry_q    <= carry_d;
      end
   end

   assign data_out = data_out_q;
   assign carry    = carry_q;

endmodule : bit_manipulation

// File: tb/tb_bit_manipulation.sv
// Scoreboard bench for bit_manipulation: expected results are queued when
// operands are driven and compared one rising edge later.
module tb_bit_manipulation;

   localparam int W = 8;

   typedef struct {
      string       tag;
      logic [W-1:0] data;
      logic        carry;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] data_in;
   logic         enable_shift, direction_shift, enable_rotate, direction_rotate;
   logic [W-1:0] data_out;
   logic         carry;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];

   bit_manipulation #(.WIDTH(W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .data_in         (data_in),
      .enable_shift    (enable_shift),
      .direction_shift (direction_shift),
      .enable_rotate   (enable_rotate),
      .direction_rotate(direction_rotate),
      .data_out        (data_out),
      .carry           (carry)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference behaviour written from the operation table.
   task automatic model(input logic [W-1:0] d, input logic es, input logic ds,
                        input logic er, input logic dr,
                        output logic [W-1:0] r, output logic c);
      if (es) begin
         if (ds) begin r = d >> 1; c = d[0]; end
         else    begin r = d << 1; c = d[W-1]; end
      end else if (er) begin
         if (dr) begin r = (d >> 1) | (d << (W-1)); c = d[0]; end
         else    begin r = (d << 1) | (d >> (W-1)); c = d[W-1]; end
      end else begin
         r = d; c = 1'b0;
      end
   endtask

   task automatic drive(input string tag, input logic [W-1:0] d, input logic es,
                        input logic ds, input logic er, input logic dr);
      exp_t e;
      data_in = d; enable_shift = es; direction_shift = ds;
      enable_rotate = er; direction_rotate = dr;
      e.tag = tag;
      model(d, es, ds, er, dr, e.data, e.carry);
      exp_q.push_back(e);
   endtask

   task automatic compare_next();
      exp_t e;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({e.tag, "_data"}, 32'(data_out), 32'(e.data));
         check({e.tag, "_carry"}, 32'(carry), 32'(e.carry));
      end
   endtask

   task automatic step(input string tag, input logic [W-1:0] d, input logic es,
                       input logic ds, input logic er, input logic dr);
      @(negedge clk);
      drive(tag, d, es, ds, er, dr);
      @(posedge clk);
      #1;
      compare_next();
   endtask

   initial begin
      rst_n = 1'b0;
      data_in = 8'hFF; enable_shift = 1'b1; direction_shift = 1'b0;
      enable_rotate = 1'b0; direction_rotate = 1'b0;
      #2;
      check("reset_async_data", 32'(data_out), 32'h00);
      check("reset_async_carry", 32'(carry), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_held_data", 32'(data_out), 32'h00);
      check("reset_held_carry", 32'(carry), 32'h0);

      @(negedge clk);
      rst_n = 1'b1;

      step("pass_0c", 8'b00001100, 1'b0, 1'b1, 1'b0, 1'b1);
      step("shl_0c",  8'b00001100, 1'b1, 1'b0, 1'b0, 1'b1);
      step("shr_0c",  8'b00001100, 1'b1, 1'b1, 1'b0, 1'b0);
      step("rol_0c",  8'b00001100, 1'b0, 1'b1, 1'b1, 1'b0);
      step("ror_0c",  8'b00001100, 1'b0, 1'b0, 1'b1, 1'b1);
      step("shl_81",  8'b10000001, 1'b1, 1'b0, 1'b0, 1'b0);
      step("shr_81",  8'b10000001, 1'b1, 1'b1, 1'b0, 1'b0);
      step("rol_81",  8'b10000001, 1'b0, 1'b0, 1'b1, 1'b0);
      step("ror_81",  8'b10000001, 1'b0, 1'b0, 1'b1, 1'b1);
      step("prio_81", 8'h81, 1'b1, 1'b1, 1'b1, 1'b0);
      step("rol_ff",  8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      step("ror_00",  8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step("shr_ff",  8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
      step("pass_ff", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

      // Fixed-value spot checks independent of the model.
      check("const_prio_hint", 32'(data_out), 32'hFF);
      step("shl_01", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
      check("const_shl_01", 32'(data_out), 32'h02);

      // Latency: a mid-cycle operand change must not reach the output early.
      #2;
      data_in = 8'h80;
      #1;
      check("latency_hold_data", 32'(data_out), 32'h02);
      check("latency_hold_carry", 32'(carry), 32'h0);
      @(negedge clk);
      check("latency_hold_negedge", 32'(data_out), 32'h02);
      drive("latency_80", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      compare_next();

      for (int i = 0; i < 24; i++) begin
         step("rand", W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      // Reset mid-stream discards the held result.
      step("pre_reset_shl", 8'h0C, 1'b1, 1'b0, 1'b0, 1'b0);
      check("const_pre_reset", 32'(data_out), 32'h18);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_data", 32'(data_out), 32'h00);
      check("midreset_carry", 32'(carry), 32'h0);
      @(negedge clk);
      data_in = 8'h81; enable_shift = 1'b0; enable_rotate = 1'b1; direction_rotate = 1'b1;
      rst_n = 1'b1;
      #1;
      check("release_no_capture", 32'(data_out), 32'h00);
      @(posedge clk);
      #1;
      check("after_release_data", 32'(data_out), 32'hC0);
      check("after_release_carry", 32'(carry), 32'h1);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_bit_manipulation
